// File: rtl/ram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ram_arb_pkg
// Brief   : Shared types and constants for the two-port data RAM arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package ram_arb_pkg;

    localparam int DEF_AW = 12;
    localparam int DEF_DW = 4;

    localparam logic P_CPU = 1'b0;
    localparam logic P_LDR = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT  = 2'd1,
        ACK  = 2'd2
    } arb_state_t;

endpackage : ram_arb_pkg
`default_nettype wire

// File: rtl/arb_rr_pick2.sv
`default_nettype none
// ============================================================================
// Module  : arb_rr_pick2
// Brief   : Combinational 2-way round-robin picker; a tie goes to the port
//           that was not served last. RAM_ARB_FIXED_PRIO_EN: port 0 wins ties.
// Revision: 1.0 - initial release
// ============================================================================
module arb_rr_pick2
    import ram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       valid,
    output logic       winner
);

`ifdef RAM_ARB_FIXED_PRIO_EN
    logic w_unused_last;
    assign w_unused_last = last;
`endif

    always_comb begin
        valid  = |req;
        winner = P_CPU;
        case (req)
            2'b01:   winner = P_CPU;
            2'b10:   winner = P_LDR;
`ifdef RAM_ARB_FIXED_PRIO_EN
            2'b11:   winner = P_CPU;
`else
            2'b11:   winner = ~last;
`endif
            default: winner = P_CPU;
        endcase
    end

endmodule : arb_rr_pick2
`default_nettype wire

// File: rtl/ram_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : ram_bus_arbiter
// Brief   : Shares one data RAM between the uP datapath (port 0) and a
//           loader/debug master (port 1) with req/gnt/ack handshakes, locked
//           bursts and round-robin fairness. Macro RAM_ARB_FIXED_PRIO_EN
//           selects fixed priority for port 0 instead of round-robin.
// Revision: 1.0 - initial release
// ============================================================================
module ram_bus_arbiter
    import ram_arb_pkg::*;
#(
    parameter int AW        = DEF_AW,
    parameter int DW        = DEF_DW,
    parameter int MAX_BURST = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          req0,
    input  logic          we0,
    input  logic          lock0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic          lock1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata,
    output logic          mem_cs,
    output logic          mem_we,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam logic [3:0] C_MAX_BURST = 4'(MAX_BURST);

    arb_state_t    r_state, w_next_state;
    logic          r_owner, w_next_owner;
    logic [3:0]    r_burst_cnt, w_next_burst;
    logic [DW-1:0] r_rdata;
    logic          w_last;
    logic          w_pick_valid;
    logic          w_pick_winner;

    logic          w_own_req;
    logic          w_own_we;
    logic          w_own_lock;
    logic [AW-1:0] w_own_addr;
    logic [DW-1:0] w_own_wdata;

    assign w_own_req   = (r_owner == P_LDR) ? req1   : req0;
    assign w_own_we    = (r_owner == P_LDR) ? we1    : we0;
    assign w_own_lock  = (r_owner == P_LDR) ? lock1  : lock0;
    assign w_own_addr  = (r_owner == P_LDR) ? addr1  : addr0;
    assign w_own_wdata = (r_owner == P_LDR) ? wdata1 : wdata0;

    arb_rr_pick2 u_pick (
        .req    ({req1, req0}),
        .last   (w_last),
        .valid  (w_pick_valid),
        .winner (w_pick_winner)
    );

`ifdef RAM_ARB_FIXED_PRIO_EN
    assign w_last = P_LDR;
`else
    logic r_rr_last;

    // Reset value P_LDR lets port 0 win the first tie.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rr_last <= P_LDR;
        end else if (r_state == GNT) begin
            r_rr_last <= r_owner;
        end
    end

    assign w_last = r_rr_last;
`endif

    always_comb begin
        w_next_state = r_state;
        w_next_owner = r_owner;
        w_next_burst = r_burst_cnt;
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_next_state = GNT;
                    w_next_owner = w_pick_winner;
                    w_next_burst = 4'd1;
                end
            end
            GNT: begin
                w_next_state = ACK;
            end
            ACK: begin
                // The picker sees the current owner as last served, so a
                // capped burst yields to the other port when it is asking.
                if (w_own_lock && w_own_req && (r_burst_cnt < C_MAX_BURST)) begin
                    w_next_state = GNT;
                    w_next_burst = r_burst_cnt + 4'd1;
                end else if (w_pick_valid) begin
                    w_next_state = GNT;
                    w_next_owner = w_pick_winner;
                    w_next_burst = 4'd1;
                end else begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_owner     <= P_CPU;
            r_burst_cnt <= 4'd0;
            r_rdata     <= '0;
        end else begin
            r_state     <= w_next_state;
            r_owner     <= w_next_owner;
            r_burst_cnt <= w_next_burst;
            if ((r_state == GNT) && !w_own_we) begin
                r_rdata <= mem_rdata;
            end
        end
    end

    assign gnt0      = (r_state == GNT) && (r_owner == P_CPU);
    assign gnt1      = (r_state == GNT) && (r_owner == P_LDR);
    assign ack0      = (r_state == ACK) && (r_owner == P_CPU);
    assign ack1      = (r_state == ACK) && (r_owner == P_LDR);
    assign mem_cs    = (r_state == GNT);
    assign mem_we    = mem_cs && w_own_we;
    assign mem_adr   = mem_cs ? w_own_addr  : '0;
    assign mem_wdata = mem_cs ? w_own_wdata : '0;
    assign rdata     = r_rdata;
    assign busy      = (r_state != IDLE);

endmodule : ram_bus_arbiter
`default_nettype wire
